// File: rtl/pc_sequencer.sv
// pc_sequencer
// Registered program counter for the single-cycle core. Chooses the next
// word address from the current instruction: sequential, conditional branch,
// absolute jump, or jump-register. It also provides a stall hold, a circular
// return-address stack (RAS) for jal / jr $31, and single-level interrupt
// entry and return with a saved EPC.
//
// Ports
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset
//   instr    : current instruction
//   zf       : ALU zero flag for the current instruction
//   rs_val   : rs register value, used as the jr target
//   stall    : holds all state while high
//   irq      : level-sensitive interrupt request
//   pc       : current PC (register)
//   pc_next  : value pc takes at the next edge (combinational)
//   epc      : return address saved by the last interrupt
//   irq_en   : interrupts accepted while high
//   ras_cnt  : number of valid RAS entries
//   ras_miss : registered one-cycle pulse after a jr $31 with the RAS empty
module pc_sequencer #(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_0040,
  parameter int unsigned RAS_DEPTH = 4,
  localparam int unsigned PTR_W    = $clog2(RAS_DEPTH),
  localparam int unsigned CNT_W    = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr,
  input  logic              zf,
  input  logic [ADDR_W-1:0] rs_val,
  input  logic              stall,
  input  logic              irq,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] epc,
  output logic              irq_en,
  output logic [CNT_W-1:0]  ras_cnt,
  output logic              ras_miss
);

  typedef enum logic [3:0] {
    ACT_HOLD,    // stalled: nothing moves
    ACT_IRQ,     // interrupt entry
    ACT_ERET,    // interrupt return
    ACT_BRANCH,  // beq / bne, taken or not
    ACT_J,
    ACT_JAL,     // jump and push return address
    ACT_POP,     // jr $31 served by the RAS
    ACT_MISS,    // jr $31 with the RAS empty
    ACT_JR,
    ACT_SEQ
  } act_e;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_COP0    = 6'b010000;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_ERET    = 6'b011000;

  logic [5:0]        op;
  logic [5:0]        fn;
  logic [ADDR_W-1:0] inc;
  logic [ADDR_W-1:0] bpc;
  logic [ADDR_W-1:0] jpc;
  logic              is_jr;
  logic              is_ret;
  logic              taken;
  act_e              act;

  // Circular stack storage; top points at the next free slot.
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  top;
  logic [PTR_W-1:0]  top_dec;

  assign op      = instr[31:26];
  assign fn      = instr[5:0];
  assign inc     = pc + ADDR_W'(1);
  assign bpc     = inc + {{(ADDR_W-16){instr[15]}}, instr[15:0]};
  assign jpc     = {pc[ADDR_W-1:26], instr[25:0]};
  assign is_jr   = (op == OP_SPECIAL) && (fn == FN_JR);
  assign is_ret  = is_jr && (instr[25:21] == 5'd31);
  assign taken   = (op == OP_BEQ) ? zf : !zf;
  assign top_dec = top - PTR_W'(1);

  // Priority decode of what this edge does.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    act = ACT_SEQ;
    if (stall)                                 act = ACT_HOLD;
    else if (irq && irq_en)                    act = ACT_IRQ;
    else if (op == OP_COP0 && fn == FN_ERET)   act = ACT_ERET;
    else if (op == OP_BEQ || op == OP_BNE)     act = ACT_BRANCH;
    else if (op == OP_J)                       act = ACT_J;
    else if (op == OP_JAL)                     act = ACT_JAL;
    else if (is_ret && ras_cnt != '0)          act = ACT_POP;
    else if (is_ret)                           act = ACT_MISS;
    else if (is_jr)                            act = ACT_JR;
  end

  always_comb begin
    pc_next = inc;
    case (act)
      ACT_HOLD:          pc_next = pc;
      ACT_IRQ:           pc_next = EXC_VEC[ADDR_W-1:0];
      ACT_ERET:          pc_next = epc;
      ACT_BRANCH:        pc_next = taken ? bpc : inc;
      ACT_J, ACT_JAL:    pc_next = jpc;
      ACT_POP:           pc_next = ras_mem[top_dec];
      ACT_MISS, ACT_JR:  pc_next = rs_val;
      default:           pc_next = inc;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_VEC[ADDR_W-1:0];
      epc      <= '0;
      irq_en   <= 1'b1;
      ras_cnt  <= '0;
      top      <= '0;
      ras_miss <= 1'b0;
    end else if (act == ACT_HOLD) begin
      ras_miss <= 1'b0;
    end else begin
      pc       <= pc_next;
      ras_miss <= (act == ACT_MISS);
      case (act)
        ACT_IRQ: begin
          epc    <= pc;
          irq_en <= 1'b0;
        end
        ACT_ERET: irq_en <= 1'b1;
        ACT_JAL: begin
          // When full the push overwrites the oldest entry; count saturates.
          top <= top + PTR_W'(1);
          if (ras_cnt != CNT_W'(RAS_DEPTH)) ras_cnt <= ras_cnt + CNT_W'(1);
        end
        ACT_POP: begin
          top     <= top_dec;
          ras_cnt <= ras_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // NOTE: the stack array has no reset; ras_cnt alone defines which entries
  // are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (rst_n && act == ACT_JAL) ras_mem[top] <= inc;
  end

endmodule
